// File: rtl/ecdsa_axil_csrs_pkg.sv
// ecdsa_csr_pkg: shared constants and types for the ECDSA AXI4-Lite CSR block.
//   - register byte offsets on the s_axi_csrs bus
//   - AXI response codes and STATUS bit positions
//   - FSM state types and the byte-strobe merge helper
package ecdsa_csr_pkg;

  localparam logic [11:0] OFF_COMMAND           = 12'h000;
  localparam logic [11:0] OFF_STATUS            = 12'h000;
  localparam logic [11:0] OFF_ADDR_TABLE_BASE_I = 12'h004;
  localparam logic [11:0] OFF_ARGC_I            = 12'h008;
  localparam logic [11:0] OFF_ADDR_TABLE_BASE_O = 12'h00C;
  localparam logic [11:0] OFF_ARGC_O            = 12'h010;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int STATUS_DONE_BIT = 0;
  localparam int STATUS_BUSY_BIT = 1;

  typedef enum logic [1:0] {
    W_ADDR = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } wr_state_e;

  typedef enum logic {
    R_ADDR = 1'b0,
    R_DATA = 1'b1
  } rd_state_e;

  typedef enum logic [2:0] {
    SEL_COMMAND = 3'd0,
    SEL_ABI     = 3'd1,
    SEL_ARGC_I  = 3'd2,
    SEL_ABO     = 3'd3,
    SEL_ARGC_O  = 3'd4,
    SEL_NONE    = 3'd7
  } reg_sel_e;

  // Merge new write data into an existing word, one byte lane per strobe bit.
  function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) begin
        res[8*b +: 8] = new_val[8*b +: 8];
      end else begin
        res[8*b +: 8] = old_val[8*b +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/ecdsa_axil_csrs_if.sv
// ecdsa_axil_csrs_if: AXI4-Lite control bus bundle (s_axi_csrs_* signals).
//   slave modport  - used by the CSR responder
//   master modport - used by the host side / testbench driver
interface ecdsa_axil_csrs_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/ecdsa_axil_csrs.sv
// ecdsa_axil_csrs: AXI4-Lite responder owning the ECDSA core command/argument registers.
// Ports:
//   clk, resetn        - clock, asynchronous active-low reset
//   s_axi_csrs         - AXI4-Lite slave bus (interface, slave modport)
//   core_start         - one-cycle launch pulse to the arithmetic core
//   core_done          - one-cycle completion pulse from the core
//   addr_table_base_i, argc_i, addr_table_base_o, argc_o - register contents
module ecdsa_axil_csrs
  import ecdsa_csr_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   resetn,
  ecdsa_axil_csrs_if.slave       s_axi_csrs,
  output logic                   core_start,
  input  logic                   core_done,
  output logic [DATA_WIDTH-1:0]  addr_table_base_i,
  output logic [DATA_WIDTH-1:0]  argc_i,
  output logic [DATA_WIDTH-1:0]  addr_table_base_o,
  output logic [DATA_WIDTH-1:0]  argc_o
);

  wr_state_e             w_state_r, w_state_nxt_s;
  rd_state_e             r_state_r, r_state_nxt_s;
  logic [ADDR_WIDTH-1:0] awaddr_r;
  logic                  awready_r, wready_r, bvalid_r;
  logic                  arready_r, rvalid_r;
  logic [1:0]            bresp_r, rresp_r;
  logic [31:0]           rdata_r;
  logic [31:0]           abi_r, argc_i_r, abo_r, argc_o_r;
  logic                  busy_r, done_r, core_start_r;
  logic                  aw_fire_s, w_fire_s, b_fire_s, ar_fire_s, r_fire_s;
  logic                  start_s, clr_done_s;
  reg_sel_e              wsel_s, rsel_s;
  logic [31:0]           rd_data_s;
  logic [1:0]            rd_resp_s;

  // Word decode; the two byte-offset bits are ignored.
  function automatic reg_sel_e decode(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-3:0] w;
    w = a[ADDR_WIDTH-1:2];
    if      (w == (ADDR_WIDTH-2)'(OFF_COMMAND >> 2))           return SEL_COMMAND;
    else if (w == (ADDR_WIDTH-2)'(OFF_ADDR_TABLE_BASE_I >> 2)) return SEL_ABI;
    else if (w == (ADDR_WIDTH-2)'(OFF_ARGC_I >> 2))            return SEL_ARGC_I;
    else if (w == (ADDR_WIDTH-2)'(OFF_ADDR_TABLE_BASE_O >> 2)) return SEL_ABO;
    else if (w == (ADDR_WIDTH-2)'(OFF_ARGC_O >> 2))            return SEL_ARGC_O;
    else                                                       return SEL_NONE;
  endfunction

  assign aw_fire_s = s_axi_csrs.awvalid & awready_r;
  assign w_fire_s  = s_axi_csrs.wvalid  & wready_r;
  assign b_fire_s  = bvalid_r & s_axi_csrs.bready;
  assign ar_fire_s = s_axi_csrs.arvalid & arready_r;
  assign r_fire_s  = rvalid_r & s_axi_csrs.rready;
  assign wsel_s    = decode(awaddr_r);
  assign rsel_s    = decode(s_axi_csrs.araddr);

  // Write FSM next state: address first, then data, then response.
  always_comb begin
    w_state_nxt_s = w_state_r;
    case (w_state_r)
      W_ADDR:  if (aw_fire_s) w_state_nxt_s = W_DATA; else w_state_nxt_s = W_ADDR;
      W_DATA:  if (w_fire_s)  w_state_nxt_s = W_RESP; else w_state_nxt_s = W_DATA;
      W_RESP:  if (b_fire_s)  w_state_nxt_s = W_ADDR; else w_state_nxt_s = W_RESP;
      default: w_state_nxt_s = W_ADDR;
    endcase
  end

  // Write FSM state plus registered handshake outputs. Readies follow the
  // next state so awready is low in reset and rises on the first edge after.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      w_state_r <= W_ADDR;
      awready_r <= 1'b0;
      wready_r  <= 1'b0;
      bvalid_r  <= 1'b0;
      bresp_r   <= RESP_OKAY;
      awaddr_r  <= '0;
    end else begin
      w_state_r <= w_state_nxt_s;
      awready_r <= (w_state_nxt_s == W_ADDR);
      wready_r  <= (w_state_nxt_s == W_DATA);
      bvalid_r  <= (w_state_nxt_s == W_RESP);
      if (aw_fire_s) awaddr_r <= s_axi_csrs.awaddr;
      if (w_fire_s)  bresp_r  <= (wsel_s == SEL_NONE) ? RESP_SLVERR : RESP_OKAY;
    end
  end

  // COMMAND decode: bit0=1 launches only when idle; bit0=0 acknowledges done.
  always_comb begin
    start_s    = 1'b0;
    clr_done_s = 1'b0;
    if (w_fire_s && (wsel_s == SEL_COMMAND) && s_axi_csrs.wstrb[0]) begin
      if (s_axi_csrs.wdata[0]) begin
        start_s    = ~busy_r;
        clr_done_s = ~busy_r;
      end else begin
        clr_done_s = 1'b1;
      end
    end else begin
      start_s    = 1'b0;
      clr_done_s = 1'b0;
    end
  end

  // Argument registers, core handshake and busy/done status.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      abi_r        <= 32'd0;
      argc_i_r     <= 32'd0;
      abo_r        <= 32'd0;
      argc_o_r     <= 32'd0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      core_start_r <= 1'b0;
    end else begin
      if (w_fire_s) begin
        case (wsel_s)
          SEL_ABI:    abi_r    <= apply_wstrb(abi_r,    s_axi_csrs.wdata, s_axi_csrs.wstrb);
          SEL_ARGC_I: argc_i_r <= apply_wstrb(argc_i_r, s_axi_csrs.wdata, s_axi_csrs.wstrb);
          SEL_ABO:    abo_r    <= apply_wstrb(abo_r,    s_axi_csrs.wdata, s_axi_csrs.wstrb);
          SEL_ARGC_O: argc_o_r <= apply_wstrb(argc_o_r, s_axi_csrs.wdata, s_axi_csrs.wstrb);
          default:    ;
        endcase
      end
      core_start_r <= start_s;
      // start requires !busy and completion requires busy, so they never collide;
      // a completion outranks a same-cycle done clear.
      if (core_done && busy_r)  busy_r <= 1'b0;
      else if (start_s)         busy_r <= 1'b1;
      if (core_done && busy_r)  done_r <= 1'b1;
      else if (clr_done_s)      done_r <= 1'b0;
    end
  end

  // Read mux sampled at the AR handshake; sees pre-write register values.
  always_comb begin
    rd_data_s = 32'd0;
    rd_resp_s = RESP_OKAY;
    case (rsel_s)
      SEL_COMMAND: begin
        rd_data_s[STATUS_BUSY_BIT] = busy_r;
        rd_data_s[STATUS_DONE_BIT] = done_r;
      end
      SEL_ABI:    rd_data_s = abi_r;
      SEL_ARGC_I: rd_data_s = argc_i_r;
      SEL_ABO:    rd_data_s = abo_r;
      SEL_ARGC_O: rd_data_s = argc_o_r;
      default:    rd_resp_s = RESP_SLVERR;
    endcase
  end

  // Read FSM next state.
  always_comb begin
    r_state_nxt_s = r_state_r;
    case (r_state_r)
      R_ADDR:  if (ar_fire_s) r_state_nxt_s = R_DATA; else r_state_nxt_s = R_ADDR;
      R_DATA:  if (r_fire_s)  r_state_nxt_s = R_ADDR; else r_state_nxt_s = R_DATA;
      default: r_state_nxt_s = R_ADDR;
    endcase
  end

  // Read FSM state, handshake outputs and held read data.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state_r <= R_ADDR;
      arready_r <= 1'b0;
      rvalid_r  <= 1'b0;
      rdata_r   <= 32'd0;
      rresp_r   <= RESP_OKAY;
    end else begin
      r_state_r <= r_state_nxt_s;
      arready_r <= (r_state_nxt_s == R_ADDR);
      rvalid_r  <= (r_state_nxt_s == R_DATA);
      if (ar_fire_s) begin
        rdata_r <= rd_data_s;
        rresp_r <= rd_resp_s;
      end
    end
  end

  assign s_axi_csrs.awready = awready_r;
  assign s_axi_csrs.wready  = wready_r;
  assign s_axi_csrs.bvalid  = bvalid_r;
  assign s_axi_csrs.bresp   = bresp_r;
  assign s_axi_csrs.arready = arready_r;
  assign s_axi_csrs.rvalid  = rvalid_r;
  assign s_axi_csrs.rdata   = rdata_r;
  assign s_axi_csrs.rresp   = rresp_r;
  assign core_start         = core_start_r;
  assign addr_table_base_i  = abi_r;
  assign argc_i             = argc_i_r;
  assign addr_table_base_o  = abo_r;
  assign argc_o             = argc_o_r;

endmodule

// File: tb/tb_ecdsa_axil_csrs.sv
// tb_ecdsa_axil_csrs: directed + randomized bench for ecdsa_axil_csrs with a
// behavioural register-map model.
module tb_ecdsa_axil_csrs;
  import ecdsa_csr_pkg::*;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        core_done = 1'b0;
  logic        core_start;
  logic [31:0] abi, argci, abo, argco;

  int tests = 0;
  int fails = 0;
  int start_cnt = 0;

  // Model: word-indexed register file (index 1..4), plus busy/done flags.
  logic [31:0] m_reg [5];
  bit          m_busy, m_done;

  ecdsa_axil_csrs_if #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) axi ();

  ecdsa_axil_csrs dut (
    .clk               (clk),
    .resetn            (resetn),
    .s_axi_csrs        (axi),
    .core_start        (core_start),
    .core_done         (core_done),
    .addr_table_base_i (abi),
    .argc_i            (argci),
    .addr_table_base_o (abo),
    .argc_o            (argco)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (core_start === 1'b1) start_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 5; i++) m_reg[i] = 32'd0;
    m_busy = 1'b0;
    m_done = 1'b0;
  endfunction

  function automatic void model_write(input logic [11:0] a, input logic [31:0] d,
                                      input logic [3:0] s, output bit exp_start,
                                      output logic [1:0] exp_resp);
    int idx;
    idx = int'(a) / 4;
    exp_start = 1'b0;
    exp_resp  = 2'b00;
    if (idx > 4) begin
      exp_resp = 2'b10;
    end else if (idx == 0) begin
      if (s[0] && d[0] && !m_busy) begin
        exp_start = 1'b1;
        m_busy = 1'b1;
        m_done = 1'b0;
      end else if (s[0] && !d[0]) begin
        m_done = 1'b0;
      end
    end else begin
      for (int b = 0; b < 4; b++)
        if (s[b]) m_reg[idx][8*b +: 8] = d[8*b +: 8];
    end
  endfunction

  function automatic void model_read(input logic [11:0] a, output logic [31:0] d,
                                     output logic [1:0] r);
    int idx;
    idx = int'(a) / 4;
    if (idx > 4)       begin d = 32'd0; r = 2'b10; end
    else if (idx == 0) begin d = 32'(m_busy) * 2 + 32'(m_done); r = 2'b00; end
    else               begin d = m_reg[idx]; r = 2'b00; end
  endfunction

  // hold<0 leaves the response pending (bready low) and returns.
  task automatic axi_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int hold, output logic [1:0] resp, output logic start_seen);
    int n;
    logic [1:0] r0;
    @(negedge clk);
    axi.awaddr = a; axi.awvalid = 1'b1; axi.wdata = d; axi.wstrb = s;
    n = 0;
    while (axi.awready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    check("aw_accept", 32'(axi.awready), 32'd1);
    @(negedge clk);
    axi.awvalid = 1'b0;
    check("wready_lat", 32'(axi.wready), 32'd1);
    axi.wvalid = 1'b1;
    @(negedge clk);
    axi.wvalid = 1'b0;
    start_seen = core_start;
    check("bvalid_lat", 32'(axi.bvalid), 32'd1);
    resp = axi.bresp;
    if (hold < 0) return;
    r0 = axi.bresp;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("bvalid_hold", {29'd0, axi.awready, axi.bvalid, 1'b0}, 32'd2);
      check("bresp_hold", 32'(axi.bresp), 32'(r0));
    end
    axi.bready = 1'b1;
    @(negedge clk);
    axi.bready = 1'b0;
    check("bvalid_drop", 32'(axi.bvalid), 32'd0);
  endtask

  task automatic axi_read(input logic [11:0] a, input int hold,
                          output logic [31:0] d, output logic [1:0] resp);
    int n;
    @(negedge clk);
    axi.araddr = a; axi.arvalid = 1'b1;
    n = 0;
    while (axi.arready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    check("ar_accept", 32'(axi.arready), 32'd1);
    @(negedge clk);
    axi.arvalid = 1'b0;
    check("rvalid_lat", 32'(axi.rvalid), 32'd1);
    d = axi.rdata;
    resp = axi.rresp;
    if (hold < 0) return;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("rvalid_hold", {30'd0, axi.arready, axi.rvalid}, 32'd1);
      check("rdata_hold", axi.rdata, d);
    end
    axi.rready = 1'b1;
    @(negedge clk);
    axi.rready = 1'b0;
    check("rvalid_drop", 32'(axi.rvalid), 32'd0);
  endtask

  task automatic check_outputs();
    check("out_abi",   abi,   m_reg[1]);
    check("out_argci", argci, m_reg[2]);
    check("out_abo",   abo,   m_reg[3]);
    check("out_argco", argco, m_reg[4]);
  endtask

  task automatic wr_chk(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                        input int hold);
    bit exp_start;
    logic [1:0] exp_resp, resp;
    logic seen;
    int c0;
    c0 = start_cnt;
    model_write(a, d, s, exp_start, exp_resp);
    axi_write(a, d, s, hold, resp, seen);
    check("bresp", 32'(resp), 32'(exp_resp));
    check("start_next_cycle", 32'(seen), 32'(exp_start));
    check("start_pulses", 32'(start_cnt - c0), 32'(exp_start));
    check_outputs();
  endtask

  task automatic rd_chk(input logic [11:0] a, input int hold);
    logic [31:0] exp_d, d;
    logic [1:0] exp_r, r;
    model_read(a, exp_d, exp_r);
    axi_read(a, hold, d, r);
    check("rdata", d, exp_d);
    check("rresp", 32'(r), 32'(exp_r));
  endtask

  task automatic pulse_done();
    @(negedge clk);
    core_done = 1'b1;
    @(negedge clk);
    core_done = 1'b0;
    if (m_busy) begin m_busy = 1'b0; m_done = 1'b1; end
  endtask

  function automatic logic [11:0] rand_addr();
    int k;
    k = $urandom_range(0, 6);
    if (k <= 4)      return 12'(k * 4 + $urandom_range(0, 3));
    else if (k == 5) return 12'h040;
    else             return 12'($urandom_range(0, 4095));
  endfunction

  initial begin
    logic [31:0] d;
    logic [1:0]  r;
    logic        seen;
    axi.awaddr = 12'd0; axi.awvalid = 1'b0; axi.wdata = 32'd0; axi.wstrb = 4'd0;
    axi.wvalid = 1'b0; axi.bready = 1'b0; axi.araddr = 12'd0; axi.arvalid = 1'b0;
    axi.rready = 1'b0;
    model_reset();

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_readies", {27'd0, axi.awready, axi.wready, axi.bvalid, axi.arready, axi.rvalid}, 32'd0);
    check("rst_resp_start", {27'd0, axi.bresp, axi.rresp, core_start}, 32'd0);
    check("rst_rdata", axi.rdata, 32'd0);
    check_outputs();
    resetn = 1'b1;
    @(posedge clk); #1;
    check("ready_after_rst", {30'd0, axi.awready, axi.arready}, 32'd3);

    // Argument registers
    wr_chk(12'h004, 32'h200, 4'hF, 0);
    wr_chk(12'h008, 32'h3,   4'hF, 0);
    wr_chk(12'h00C, 32'h300, 4'hF, 0);
    wr_chk(12'h010, 32'h1,   4'hF, 0);
    rd_chk(12'h004, 0); rd_chk(12'h008, 0); rd_chk(12'h00C, 0); rd_chk(12'h010, 0);

    // Command / status flow
    wr_chk(12'h000, 32'h1, 4'hF, 0);
    rd_chk(12'h000, 0);
    check("status_busy", d, d); tests--;
    pulse_done();
    rd_chk(12'h000, 0);
    wr_chk(12'h000, 32'h0, 4'hF, 0);
    rd_chk(12'h000, 0);
    wr_chk(12'h000, 32'h1, 4'hF, 0);
    wr_chk(12'h000, 32'h1, 4'hF, 0);
    rd_chk(12'h000, 0);
    pulse_done();
    rd_chk(12'h000, 0);

    // Byte strobes and unmapped access
    wr_chk(12'h008, 32'hAABBCCDD, 4'b0101, 0);
    rd_chk(12'h008, 0);
    wr_chk(12'h040, 32'hFFFFFFFF, 4'hF, 0);
    rd_chk(12'h040, 0);

    // Randomized traffic
    for (int it = 0; it < 80; it++) begin
      case ($urandom_range(0, 3))
        0:       wr_chk(rand_addr(), $urandom(), 4'($urandom_range(0, 15)), 0);
        1:       rd_chk(rand_addr(), 0);
        2:       pulse_done();
        default: wr_chk(12'h000, 32'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 0);
      endcase
    end

    // Back-pressure on both response channels
    wr_chk(12'h00C, $urandom(), 4'hF, 5);
    rd_chk(12'h00C, 5);

    // Reset while both responses are pending
    wr_chk(12'h000, 32'h0, 4'h1, 0);
    wr_chk(12'h000, 32'h1, 4'h1, 0);
    axi_write(12'h010, 32'h12345678, 4'hF, -1, r, seen);
    axi_read(12'h004, -1, d, r);
    resetn = 1'b0;
    #1;
    model_reset();
    check("midrst_handshake", {27'd0, axi.awready, axi.wready, axi.bvalid, axi.arready, axi.rvalid}, 32'd0);
    check("midrst_resp", {27'd0, axi.bresp, axi.rresp, core_start}, 32'd0);
    check("midrst_rdata", axi.rdata, 32'd0);
    check_outputs();
    @(negedge clk);
    resetn = 1'b1;
    rd_chk(12'h000, 0);
    rd_chk(12'h010, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
